// File: rtl/inpdt_mac_acc.sv
// Zero-point-corrected integer inner-product engine: streams LANES byte pairs per beat,
// accumulates (x-ZERO_DATA)*(w-ZERO_W) over NUM_BEATS beats, and returns the 32-bit sum.
module inpdt_mac_acc #(
    parameter logic [7:0] ZERO_DATA = 8'd128,
    parameter logic [7:0] ZERO_W    = 8'd128,
    parameter int         LANES     = 4,
    parameter int         NUM_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   data_in,
    input  logic [8*LANES-1:0]   weight_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          inpdt_R_reg,
    output logic                 busy,
    output logic [1:0]           o_dbg_state
);
    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready.
    localparam int CW = $clog2(NUM_BEATS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_beat_cnt;
    logic                  r_s1_valid;
    logic signed [19:0]    r_s1_sum;
    logic signed [31:0]    r_acc;

    logic                  w_accept;
    logic                  w_last;
    logic signed [17:0]    w_prods [LANES];
    logic signed [19:0]    w_lane_sum;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [8:0] w_dx;
        logic signed [8:0] w_dw;
        assign w_dx       = $signed({1'b0, data_in[8*g +: 8]})   - $signed({1'b0, ZERO_DATA});
        assign w_dw       = $signed({1'b0, weight_in[8*g +: 8]}) - $signed({1'b0, ZERO_W});
        assign w_prods[g] = w_dx * w_dw;
    end

    always_comb begin
        w_lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_sum = w_lane_sum + 20'(w_prods[l]);
        end
    end

    assign w_accept    = in_valid && (r_state == S_ACC);
    assign w_last      = (r_beat_cnt == CW'(NUM_BEATS - 1));
    assign in_ready    = (r_state == S_ACC);
    assign out_valid   = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign inpdt_R_reg = r_acc;
    assign o_dbg_state = r_state;

    // DRAIN exists so the final S1 sum lands in r_acc before DONE is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_acc      <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sum <= w_lane_sum;
            end
            if (r_s1_valid) begin
                r_acc <= r_acc + 32'(r_s1_sum);
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_ACC;
                        r_acc      <= '0;
                        r_beat_cnt <= '0;
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + CW'(1);
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: r_state <= S_DONE;
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inpdt_mac_acc.sv
// Directed bench for inpdt_mac_acc: fixed-pattern vectors, a random gapped vector,
// ignored start/in_valid, stalled output and a mid-vector reset.
module tb_inpdt_mac_acc;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [31:0] weight_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inpdt_R_reg;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] dv [16];
  logic [31:0] wv [16];
  logic [31:0] exp_val;

  inpdt_mac_acc dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .weight_in   (weight_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .inpdt_R_reg (inpdt_R_reg),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: signed sum over beats and lanes of (x-128)*(w-128).
  function automatic logic [31:0] model(input logic [31:0] d [16], input logic [31:0] w [16]);
    int s = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) begin
        s += (int'({24'd0, d[i][8*k +: 8]}) - 128) * (int'({24'd0, w[i][8*k +: 8]}) - 128);
      end
    end
    return s;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d [16], input logic [31:0] w [16],
                      input bit gaps, input bit poke_start);
    for (int i = 0; i < 16; i++) begin
      int g;
      g = gaps ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        in_valid  = 1'b0;
        data_in   = $urandom;
        weight_in = $urandom;
        tick();
      end
      in_valid  = 1'b1;
      data_in   = d[i];
      weight_in = w[i];
      start     = poke_start && (i == 5);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  // Called right after the edge that accepted beat 16.
  task automatic finish_vec(input string tag, input logic [31:0] exp);
    check({tag, "_drain_in_ready"}, in_ready, 1'b0);
    check({tag, "_drain_out_valid"}, out_valid, 1'b0);
    check({tag, "_drain_busy"}, busy, 1'b1);
    tick();
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_result"}, inpdt_R_reg, exp);
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_clr"}, out_valid, 1'b0);
    check({tag, "_busy_clr"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; weight_in = '0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", inpdt_R_reg, 32'd0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    tick();

    // in_valid in IDLE and during the start cycle must not be taken.
    in_valid = 1'b1; data_in = 32'hFFFF_FFFF; weight_in = 32'hFFFF_FFFF;
    repeat (2) tick();
    check("idle_in_ready", in_ready, 1'b0);
    check("idle_busy", busy, 1'b0);
    pulse_start();
    in_valid = 1'b0;
    check("acc_in_ready", in_ready, 1'b1);
    check("acc_busy", busy, 1'b1);

    // Case 1: all zero-point bytes.
    for (int i = 0; i < 16; i++) begin dv[i] = 32'h8080_8080; wv[i] = 32'h8080_8080; end
    feed(dv, wv, 1'b0, 1'b0);
    finish_vec("zero_pt", 32'd0);
    take_result("zero_pt");

    // Case 2: max positive, plus in_valid held in DONE while stalled.
    for (int i = 0; i < 16; i++) begin dv[i] = 32'hFFFF_FFFF; wv[i] = 32'hFFFF_FFFF; end
    pulse_start();
    feed(dv, wv, 1'b0, 1'b0);
    finish_vec("max_pos", 32'h000F_C040);
    in_valid = 1'b1; data_in = 32'h0; weight_in = 32'hFFFF_FFFF;
    repeat (3) tick();
    in_valid = 1'b0;
    check("done_in_valid_result", inpdt_R_reg, 32'h000F_C040);
    check("done_in_valid_out_valid", out_valid, 1'b1);
    take_result("max_pos");
    check("idle_hold_result", inpdt_R_reg, 32'h000F_C040);

    // Case 3: negative, with start poked mid-vector.
    for (int i = 0; i < 16; i++) begin dv[i] = 32'h0000_0000; wv[i] = 32'hFFFF_FFFF; end
    pulse_start();
    check("start_clears_acc", inpdt_R_reg, 32'd0);
    feed(dv, wv, 1'b0, 1'b1);
    finish_vec("neg", 32'hFFF0_2000);
    take_result("neg");

    // Case 4: random bytes with gaps, output stalled for 10 cycles.
    for (int i = 0; i < 16; i++) begin dv[i] = $urandom; wv[i] = $urandom; end
    exp_val = model(dv, wv);
    pulse_start();
    feed(dv, wv, 1'b1, 1'b0);
    finish_vec("rand", exp_val);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_result", inpdt_R_reg, exp_val);
    end
    take_result("rand");

    // Case 6: reset after beat 7, then a clean case-2 vector.
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; data_in = 32'h0000_0000; weight_in = 32'hFFFF_FFFF;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_result", inpdt_R_reg, 32'd0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", busy, 1'b0);
    for (int i = 0; i < 16; i++) begin dv[i] = 32'hFFFF_FFFF; wv[i] = 32'hFFFF_FFFF; end
    pulse_start();
    feed(dv, wv, 1'b0, 1'b0);
    finish_vec("post_rst", 32'h000F_C040);
    take_result("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
